datamem_ctrl: RTL and testbench

Parametrised, handshaked successor to the single-cycle data memory. It sits between the core's memory stage and a byte-addressed RAM plus a bank of memory-mapped I/O channels. Requests pass through a valid/ready handshake and complete after a configurable latency with a response handshake. Misaligned, out-of-range and illegal accesses are flagged instead of silently wrapping.

---
 rtl/datamem_ctrl.sv | 170 +++++++++++++++++
 tb/tb_datamem_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/datamem_ctrl.sv
// Handshaked data-memory controller: byte-addressed RAM plus a memory-mapped I/O window.
// Requests are decoded and committed on the accept edge; the response appears after LATENCY edges.
module datamem_ctrl #(
  parameter int unsigned MEM_BYTES = 131072,
  parameter int unsigned NUM_IO    = 2,
  parameter logic [31:0] IO_BASE   = 32'hFFFFFF00,
  parameter int unsigned LATENCY   = 2,
  parameter string       INIT_FILE = "",
  parameter int unsigned INIT_BASE = 'h10000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [31:0]          req_addr,
  input  logic                 req_wen,
  input  logic [2:0]           req_width,
  input  logic [31:0]          req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_rdata,
  output logic                 resp_err,
  input  logic [NUM_IO*32-1:0] io_in,
  output logic [NUM_IO*32-1:0] io_out
);

  localparam int unsigned AW = $clog2(MEM_BYTES);
  localparam int unsigned CW = 3;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  localparam logic [2:0] WID_W  = 3'b000;
  localparam logic [2:0] WID_H  = 3'b001;
  localparam logic [2:0] WID_B  = 3'b010;
  localparam logic [2:0] WID_HU = 3'b101;
  localparam logic [2:0] WID_BU = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [7:0]      mem [MEM_BYTES];

  logic            accept;
  logic [2:0]      size;
  logic            width_ok, store_ok, align_ok;
  logic            ram_hit, ram_ok, io_hit, io_ok, acc_err;
  logic [32:0]     ram_end;
  logic [31:0]     io_off, io_word;
  logic [AW-1:0]   ram_idx;
  logic [31:0]     ram_word, ram_rdata, io_rdata, load_data;
  logic            ram_we, io_we;

  assign accept = (state_q == S_IDLE) && req_valid;

  // Request decode and legality checks
  always_comb begin
    size     = 3'd4;
    width_ok = 1'b1;
    align_ok = 1'b1;
    unique case (req_width)
      WID_W:         begin size = 3'd4; align_ok = (req_addr[1:0] == 2'b00); end
      WID_H, WID_HU: begin size = 3'd2; align_ok = (req_addr[0] == 1'b0); end
      WID_B, WID_BU: size = 3'd1;
      default:       width_ok = 1'b0;
    endcase
    store_ok = !(req_wen && ((req_width == WID_HU) || (req_width == WID_BU)));

    // 33-bit arithmetic so an access straddling the top of RAM never wraps
    ram_hit = ({1'b0, req_addr} < 33'(MEM_BYTES));
    ram_end = {1'b0, req_addr} + 33'(size) - 33'd1;
    ram_ok  = ram_hit && (ram_end < 33'(MEM_BYTES));

    io_hit  = !ram_hit && (req_addr >= IO_BASE);
    io_off  = req_addr - IO_BASE;
    io_word = io_off >> 2;
    io_ok   = io_hit && (req_width == WID_W) && (io_word < 32'(NUM_IO));

    acc_err = !width_ok || !store_ok || !align_ok || !(ram_ok || io_ok);
  end

  // Little-endian load path
  always_comb begin
    ram_idx  = req_addr[AW-1:0];
    ram_word = {mem[AW'(ram_idx + AW'(3))], mem[AW'(ram_idx + AW'(2))],
                mem[AW'(ram_idx + AW'(1))], mem[ram_idx]};
    unique case (req_width)
      WID_H:   ram_rdata = {{16{ram_word[15]}}, ram_word[15:0]};
      WID_HU:  ram_rdata = {16'h0000, ram_word[15:0]};
      WID_B:   ram_rdata = {{24{ram_word[7]}}, ram_word[7:0]};
      WID_BU:  ram_rdata = {24'h000000, ram_word[7:0]};
      default: ram_rdata = ram_word;
    endcase

    io_rdata = 32'h0;
    for (int k = 0; k < int'(NUM_IO); k++) begin
      if (io_word == 32'(k)) io_rdata = io_in[32*k +: 32];
    end

    if (acc_err || req_wen) load_data = 32'h0;
    else if (ram_ok)        load_data = ram_rdata;
    else                    load_data = io_rdata;

    ram_we = accept && req_wen && !acc_err && ram_ok;
    io_we  = accept && req_wen && !acc_err && io_ok;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      io_out     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_ready  <= (state_d == S_IDLE);
      resp_valid <= (state_d == S_RESP);
      if (accept) begin
        resp_rdata <= load_data;
        resp_err   <= acc_err;
      end
      if (io_we) begin
        for (int k = 0; k < int'(NUM_IO); k++) begin
          if (io_word == 32'(k)) io_out[32*k +: 32] <= req_wdata;
        end
      end
    end
  end

  // RAM byte writes; reset suppresses a same-cycle accept
  always_ff @(posedge clk) begin
    if (!rst && ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < size) mem[AW'(ram_idx + AW'(i))] <= req_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_datamem_ctrl.sv
// Directed self-checking bench for datamem_ctrl (LATENCY=2, NUM_IO=2).
module tb_datamem_ctrl;

  localparam logic [2:0] W  = 3'b000;
  localparam logic [2:0] H  = 3'b001;
  localparam logic [2:0] B  = 3'b010;
  localparam logic [2:0] HU = 3'b101;
  localparam logic [2:0] BU = 3'b110;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_width;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [63:0] io_in, io_out;

  int checks = 0;
  int errors = 0;

  datamem_ctrl #(
    .MEM_BYTES(131072), .NUM_IO(2), .IO_BASE(32'hFFFFFF00), .LATENCY(2)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wen(req_wen), .req_width(req_width), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .io_in(io_in), .io_out(io_out)
  );

  always #5 clk = ~clk;

  // One full transaction with resp_ready high; lat = edges from accept to the handshake edge.
  task automatic xact(input logic [31:0] addr, input logic wen, input logic [2:0] width,
                      input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                      output int lat, output logic [63:0] io_acc);
    int n;
    req_addr = addr; req_wen = wen; req_width = width; req_wdata = wdata;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL xact_ready_timeout: req_ready stuck at 0 for addr %h", addr);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    io_acc = io_out;
    lat = 1;
    while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    if (!resp_valid) begin
      checks++; errors++;
      $display("FAIL xact_resp_timeout: no resp_valid for addr %h", addr);
    end
    rdata = resp_rdata;
    err   = resp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", resp_err); end
    checks++; if (io_out !== 64'h0) begin errors++; $display("FAIL reset_io_out: got %h want 0", io_out); end
    rst = 1'b0;
  endtask

  task automatic test_ram();
    logic [31:0] rd, la [4], ex [4];
    logic [2:0]  lw [4];
    logic        er;
    logic [63:0] acc;
    int          lat;
    xact(32'h100, 1'b1, W, 32'hDEADBEEF, rd, er, lat, acc);
    checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL sw_resp: got err %b rdata %h want 0/0", er, rd); end
    checks++; if (lat != 2) begin errors++; $display("FAIL sw_latency: got %0d want 2", lat); end
    xact(32'h100, 1'b0, W, 32'h0, rd, er, lat, acc);
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL lw_data: got %h err %b want deadbeef/0", rd, er); end
    checks++; if (lat != 2) begin errors++; $display("FAIL lw_latency: got %0d want 2", lat); end
    la = '{32'h103, 32'h103, 32'h102, 32'h100};
    lw = '{B, BU, H, HU};
    ex = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
    for (int i = 0; i < 4; i++) begin
      xact(la[i], 1'b0, lw[i], 32'h0, rd, er, lat, acc);
      checks++;
      if (rd !== ex[i] || er !== 1'b0) begin
        errors++; $display("FAIL subword_load_%0d: got %h err %b want %h/0", i, rd, er, ex[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd, ea [8], ed [8];
    logic [2:0]  ew [8];
    logic        en [8];
    logic        er;
    logic [63:0] acc;
    int          lat;
    xact(32'h0, 1'b1, W, 32'h11223344, rd, er, lat, acc);
    xact(32'h1FFFC, 1'b1, W, 32'hCAFEF00D, rd, er, lat, acc);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL top_word_store: got err %b want 0", er); end
    ea = '{32'h101, 32'h20000, 32'h100, 32'h1FFFE, 32'h100, 32'h100, 32'h80000000, 32'h1FFFE};
    en = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    ew = '{H, W, BU, W, 3'b011, 3'b111, W, W};
    ed = '{32'h1234, 32'h0, 32'h55, 32'h0, 32'h0, 32'h0, 32'h0, 32'hAAAAAAAA};
    for (int i = 0; i < 8; i++) begin
      xact(ea[i], en[i], ew[i], ed[i], rd, er, lat, acc);
      checks++;
      if (er !== 1'b1 || rd !== 32'h0) begin
        errors++; $display("FAIL error_case_%0d: got err %b rdata %h want 1/0", i, er, rd);
      end
    end
    xact(32'h100, 1'b0, W, 32'h0, rd, er, lat, acc);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_unchanged_100: got %h want deadbeef", rd); end
    xact(32'h0, 1'b0, W, 32'h0, rd, er, lat, acc);
    checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL no_wrap_0: got %h want 11223344", rd); end
    xact(32'h1FFFC, 1'b0, W, 32'h0, rd, er, lat, acc);
    checks++; if (rd !== 32'hCAFEF00D || er !== 1'b0) begin errors++; $display("FAIL top_word_load: got %h err %b want cafef00d/0", rd, er); end
  endtask

  task automatic test_io();
    logic [31:0] rd;
    logic        er;
    logic [63:0] acc;
    int          lat;
    io_in = 64'h00000055_12345678;
    xact(32'hFFFFFF04, 1'b0, W, 32'h0, rd, er, lat, acc);
    checks++; if (rd !== 32'h55 || er !== 1'b0) begin errors++; $display("FAIL io_load_ch1: got %h err %b want 55/0", rd, er); end
    xact(32'hFFFFFF00, 1'b0, W, 32'h0, rd, er, lat, acc);
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL io_load_ch0: got %h want 12345678", rd); end
    xact(32'hFFFFFF00, 1'b1, W, 32'hA5, rd, er, lat, acc);
    checks++; if (acc !== 64'h00000000_000000A5) begin errors++; $display("FAIL io_store_accept: got %h want a5 in ch0", acc); end
    checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL io_store_resp: got err %b rdata %h want 0/0", er, rd); end
    xact(32'hFFFFFF08, 1'b0, W, 32'h0, rd, er, lat, acc);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL io_bad_channel: got err %b rdata %h want 1/0", er, rd); end
    xact(32'hFFFFFF00, 1'b0, B, 32'h0, rd, er, lat, acc);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL io_byte_load: got err %b want 1", er); end
    xact(32'hFFFFFF04, 1'b1, H, 32'hFFFF, rd, er, lat, acc);
    checks++; if (er !== 1'b1 || io_out !== 64'h00000000_000000A5) begin errors++; $display("FAIL io_half_store: got err %b io_out %h want 1/a5", er, io_out); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd;
    logic        er;
    logic [63:0] acc;
    int          lat, n;
    resp_ready = 1'b0;
    req_addr = 32'h100; req_wen = 1'b0; req_width = W; req_wdata = 32'h0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_addr = 32'h200; req_wen = 1'b1; req_wdata = 32'h0000CAFE;
    n = 0;
    while (!resp_valid && n < 20) begin @(posedge clk); #1; n++; end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: got valid %b rdata %h ready %b want 1/deadbeef/0", c, resp_valid, resp_rdata, req_ready);
      end
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_handshake: got valid %b ready %b want 0/1", resp_valid, req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_second_accept: got ready %b want 0", req_ready); end
    n = 0;
    while (!resp_valid && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin errors++; $display("FAIL bp_second_resp: got valid %b err %b rdata %h want 1/0/0", resp_valid, resp_err, resp_rdata); end
    @(posedge clk); #1;
    repeat (2) begin
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++; $display("FAIL bp_no_double_accept: got valid %b ready %b want 0/1", resp_valid, req_ready);
      end
      @(posedge clk); #1;
    end
    xact(32'h200, 1'b0, W, 32'h0, rd, er, lat, acc);
    checks++; if (rd !== 32'h0000CAFE) begin errors++; $display("FAIL bp_stored_value: got %h want 0000cafe", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic        er;
    logic [63:0] acc;
    int          lat;
    req_addr = 32'h10; req_wen = 1'b1; req_width = W; req_wdata = 32'h77;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ctrl: got valid %b ready %b want 0/1", resp_valid, req_ready); end
    checks++; if (io_out !== 64'h0) begin errors++; $display("FAIL rst_mid_io_out: got %h want 0", io_out); end
    xact(32'h10, 1'b0, W, 32'h0, rd, er, lat, acc);
    checks++; if (rd !== 32'h77 || er !== 1'b0) begin errors++; $display("FAIL rst_mid_data_kept: got %h err %b want 77/0", rd, er); end
  endtask

  task automatic test_reset_collide();
    logic [31:0] rd;
    logic        er;
    logic [63:0] acc;
    int          lat;
    req_addr = 32'h10; req_wen = 1'b1; req_width = W; req_wdata = 32'h99;
    req_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    repeat (3) begin
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++; $display("FAIL rst_collide_ctrl: got valid %b ready %b want 0/1", resp_valid, req_ready);
      end
      @(posedge clk); #1;
    end
    xact(32'h10, 1'b0, W, 32'h0, rd, er, lat, acc);
    checks++; if (rd !== 32'h77) begin errors++; $display("FAIL rst_collide_no_write: got %h want 77", rd); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = 32'h0; req_wen = 1'b0;
    req_width = W; req_wdata = 32'h0; resp_ready = 1'b1; io_in = 64'h0;
    test_reset();
    test_ram();
    test_errors();
    test_io();
    test_backpressure();
    test_reset_mid();
    test_reset_collide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
